// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: jump-kind encodings and the jump-redirect controller states.
// Reused by the decoder, the PC-jump calculator and the redirect controller.
package mips_pkg;

    localparam logic [1:0] JUMP_J    = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;
    localparam logic [1:0] JUMP_JR   = 2'b11;

    typedef enum logic [1:0] {
        JRC_IDLE     = 2'b00,
        JRC_WAIT_RS  = 2'b01,
        JRC_REDIRECT = 2'b10
    } jrc_state_e;

    // Jump kinds that write a return address.
    function automatic logic is_link_kind(input logic [1:0] kind);
        return (kind == JUMP_JAL) || (kind == JUMP_JALR);
    endfunction

    // Jump kinds whose target depends on a source register.
    function automatic logic is_reg_kind(input logic [1:0] kind);
        return kind[1];
    endfunction

endpackage

// File: rtl/jump_redirect_controller.sv
// Sequences unconditional jumps from ID into fetch: stalls on a pending rs, captures the target,
// then issues a one-cycle PC load / IF flush / link write. Keeps redirect stats and a watchdog error.
module jump_redirect_controller
    import mips_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_WAIT  = 4,
    parameter int MAX_WAIT = 15,
    parameter int NB_COUNT = 16
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_id_valid,
    input  logic                i_is_jump,
    input  logic [1:0]          i_jump,
    input  logic                i_rs_busy,
    input  logic                i_halt,
    input  logic [NB_DATA-1:0]  i_pc_jump,
    input  logic [NB_DATA-1:0]  i_pc_next,
    output logic                o_stall,
    output logic                o_pc_load,
    output logic [NB_DATA-1:0]  o_pc_target,
    output logic                o_flush_if,
    output logic                o_link_we,
    output logic [NB_DATA-1:0]  o_link_data,
    output logic [NB_COUNT-1:0] o_redirect_count,
    output logic                o_wait_error
);

    jrc_state_e          state_r;
    logic [NB_WAIT-1:0]  wait_cnt_r;
    logic [NB_COUNT-1:0] redirect_count_r;
    logic [NB_DATA-1:0]  pc_target_r;
    logic [NB_DATA-1:0]  link_data_r;
    logic                pc_load_r;
    logic                flush_if_r;
    logic                link_we_r;
    logic                wait_error_r;
    logic                det_s;
    logic                issue_s;
    logic                stall_s;

    // Jump detection, stall request and the "capture target and redirect next cycle" decision.
    always_comb begin
        det_s   = i_id_valid & i_is_jump & ~i_halt;
        issue_s = 1'b0;
        stall_s = 1'b0;
        case (state_r)
            JRC_IDLE: begin
                stall_s = det_s;
                issue_s = det_s & (~is_reg_kind(i_jump) | ~i_rs_busy);
            end
            JRC_WAIT_RS: begin
                stall_s = 1'b1;
                issue_s = ~i_halt & ~i_rs_busy;
            end
            JRC_REDIRECT: begin
                stall_s = 1'b0;
                issue_s = 1'b0;
            end
            default: begin
                stall_s = 1'b0;
                issue_s = 1'b0;
            end
        endcase
    end

    // Controller state, captured target/link, redirect pulses, watchdog and statistics.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r          <= JRC_IDLE;
            wait_cnt_r       <= '0;
            redirect_count_r <= '0;
            pc_target_r      <= '0;
            link_data_r      <= '0;
            pc_load_r        <= 1'b0;
            flush_if_r       <= 1'b0;
            link_we_r        <= 1'b0;
            wait_error_r     <= 1'b0;
        end else begin
            // Pulses are asserted exactly while the state register holds REDIRECT.
            pc_load_r  <= issue_s;
            flush_if_r <= issue_s;
            link_we_r  <= issue_s & is_link_kind(i_jump);
            if (issue_s) begin
                pc_target_r <= i_pc_jump;
                link_data_r <= i_pc_next;
            end
            case (state_r)
                JRC_IDLE: begin
                    if (issue_s) begin
                        state_r <= JRC_REDIRECT;
                    end else if (det_s) begin
                        state_r    <= JRC_WAIT_RS;
                        wait_cnt_r <= '0;
                    end else begin
                        state_r <= JRC_IDLE;
                    end
                end
                JRC_WAIT_RS: begin
                    if (i_halt) begin
                        state_r <= JRC_WAIT_RS;
                    end else if (issue_s) begin
                        state_r <= JRC_REDIRECT;
                    end else if (wait_cnt_r == NB_WAIT'(MAX_WAIT - 1)) begin
                        wait_error_r <= 1'b1;
                        state_r      <= JRC_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + NB_WAIT'(1);
                    end
                end
                JRC_REDIRECT: begin
                    if (redirect_count_r != {NB_COUNT{1'b1}}) begin
                        redirect_count_r <= redirect_count_r + NB_COUNT'(1);
                    end
                    state_r <= JRC_IDLE;
                end
                default: begin
                    state_r <= JRC_IDLE;
                end
            endcase
        end
    end

    assign o_stall          = stall_s;
    assign o_pc_load        = pc_load_r;
    assign o_flush_if       = flush_if_r;
    assign o_link_we        = link_we_r;
    assign o_pc_target      = pc_target_r;
    assign o_link_data      = link_data_r;
    assign o_redirect_count = redirect_count_r;
    assign o_wait_error     = wait_error_r;

endmodule

// File: tb/tb_jump_redirect_controller.sv
// Self-checking bench for jump_redirect_controller: directed scenarios plus randomized jumps
// checked against latency/count rules computed in the bench.
module tb_jump_redirect_controller;
    import mips_pkg::*;

    localparam int NBD     = 32;
    localparam int NBC     = 8;
    localparam int CNT_MAX = (1 << NBC) - 1;

    logic            i_clock = 1'b0;
    logic            i_reset_n = 1'b0;
    logic            i_id_valid = 1'b0, i_is_jump = 1'b0, i_rs_busy = 1'b0, i_halt = 1'b0;
    logic [1:0]      i_jump = 2'b00;
    logic [NBD-1:0]  i_pc_jump = '0, i_pc_next = '0;
    logic            o_stall, o_pc_load, o_flush_if, o_link_we, o_wait_error;
    logic [NBD-1:0]  o_pc_target, o_link_data;
    logic [NBC-1:0]  o_redirect_count;

    int n_checks = 0;
    int n_fail = 0;
    int exp_count = 0;
    logic exp_err = 1'b0;

    always #5 i_clock = ~i_clock;

    jump_redirect_controller #(
        .NB_DATA(NBD), .NB_WAIT(4), .MAX_WAIT(15), .NB_COUNT(NBC)
    ) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_id_valid(i_id_valid),
        .i_is_jump(i_is_jump), .i_jump(i_jump), .i_rs_busy(i_rs_busy), .i_halt(i_halt),
        .i_pc_jump(i_pc_jump), .i_pc_next(i_pc_next), .o_stall(o_stall),
        .o_pc_load(o_pc_load), .o_pc_target(o_pc_target), .o_flush_if(o_flush_if),
        .o_link_we(o_link_we), .o_link_data(o_link_data),
        .o_redirect_count(o_redirect_count), .o_wait_error(o_wait_error)
    );

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic set_idle();
        i_id_valid = 1'b0; i_is_jump = 1'b0; i_jump = 2'b00; i_rs_busy = 1'b0;
        i_halt = 1'b0; i_pc_jump = '0; i_pc_next = '0;
    endtask

    // One jump of a given kind with k busy cycles (busy only matters for JR/JALR).
    task automatic do_jump(input logic [1:0] kind, input int k,
                           input logic [NBD-1:0] tgt, input logic [NBD-1:0] nxt);
        int   busy;
        logic lnk;
        busy = kind[1] ? k : 0;
        lnk  = (kind == JUMP_JAL) || (kind == JUMP_JALR);
        for (int c = 0; c <= busy; c++) begin
            i_id_valid = 1'b1; i_is_jump = 1'b1; i_jump = kind; i_halt = 1'b0;
            i_pc_next = nxt; i_rs_busy = (c < busy);
            i_pc_jump = (c < busy) ? $urandom : tgt;
            @(negedge i_clock);
            n_checks++;
            if ({o_stall, o_pc_load, o_flush_if, o_link_we} !== 4'b1000) begin
                n_fail++;
                $display("FAIL jump_stall kind=%0d cyc=%0d: stall/load/flush/we got %b want 1000",
                         kind, c, {o_stall, o_pc_load, o_flush_if, o_link_we});
            end
            n_checks++;
            if (o_redirect_count !== exp_count[NBC-1:0] || o_wait_error !== exp_err) begin
                n_fail++;
                $display("FAIL jump_stats: count/err got %0d/%b want %0d/%b",
                         o_redirect_count, o_wait_error, exp_count, exp_err);
            end
            tick();
        end
        // Redirect cycle: inputs are junk and must be ignored.
        i_id_valid = 1'($urandom); i_is_jump = 1'($urandom); i_jump = 2'($urandom);
        i_halt = 1'($urandom); i_rs_busy = 1'($urandom);
        i_pc_jump = $urandom; i_pc_next = $urandom;
        @(negedge i_clock);
        n_checks++;
        if ({o_stall, o_pc_load, o_flush_if, o_link_we} !== {3'b011, lnk}) begin
            n_fail++;
            $display("FAIL redirect_ctrl kind=%0d: stall/load/flush/we got %b want %b",
                     kind, {o_stall, o_pc_load, o_flush_if, o_link_we}, {3'b011, lnk});
        end
        n_checks++;
        if (o_pc_target !== tgt || o_link_data !== nxt) begin
            n_fail++;
            $display("FAIL redirect_data: target/link got %h/%h want %h/%h",
                     o_pc_target, o_link_data, tgt, nxt);
        end
        tick();
        if (exp_count < CNT_MAX) exp_count++;
        set_idle();
        n_checks++;
        if (o_pc_load !== 1'b0 || o_pc_target !== tgt) begin
            n_fail++;
            $display("FAIL target_hold: load/target got %b/%h want 0/%h", o_pc_load, o_pc_target, tgt);
        end
    endtask

    task automatic test_reset();
        set_idle();
        i_reset_n = 1'b0;
        #3;
        n_checks++;
        if ({o_stall, o_pc_load, o_flush_if, o_link_we, o_wait_error} !== 5'b0 ||
            o_pc_target !== '0 || o_link_data !== '0 || o_redirect_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ctrl=%b target=%h link=%h count=%0d want all zero",
                     {o_stall, o_pc_load, o_flush_if, o_link_we, o_wait_error},
                     o_pc_target, o_link_data, o_redirect_count);
        end
        @(negedge i_clock);
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        do_jump(JUMP_J,   0, 32'h0040_0020, 32'h0000_0104);
        do_jump(JUMP_JAL, 0, 32'h0040_1000, 32'h0000_0200);
        do_jump(JUMP_JR,  3, 32'h0000_0800, 32'h0000_0304);
        do_jump(JUMP_JALR, 0, 32'h0000_0A00, 32'h0000_0308);
    endtask

    task automatic test_halt_detect();
        for (int c = 0; c < 3; c++) begin
            i_id_valid = 1'b1; i_is_jump = 1'b1; i_jump = 2'($urandom); i_halt = 1'b1;
            i_rs_busy = 1'($urandom); i_pc_jump = $urandom;
            @(negedge i_clock);
            n_checks++;
            if (o_stall !== 1'b0 || o_pc_load !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_detect: stall/load got %b/%b want 0/0", o_stall, o_pc_load);
            end
            tick();
        end
        set_idle();
        do_jump(JUMP_J, 0, 32'h0000_5550, 32'h0000_0110);
    endtask

    // JR held busy: 1 wait cycle, 5 halted, 13 more busy (14 counted, one short of the limit).
    task automatic test_halt_in_wait();
        for (int c = 0; c < 20; c++) begin
            i_id_valid = 1'b1; i_is_jump = 1'b1; i_jump = JUMP_JR; i_pc_next = 32'h0000_0404;
            i_rs_busy = 1'b1; i_pc_jump = $urandom; i_halt = (c >= 2 && c < 7);
            @(negedge i_clock);
            n_checks++;
            if ({o_stall, o_pc_load, o_wait_error} !== 3'b100) begin
                n_fail++;
                $display("FAIL halt_wait cyc=%0d: stall/load/err got %b want 100",
                         c, {o_stall, o_pc_load, o_wait_error});
            end
            tick();
        end
        i_rs_busy = 1'b0; i_halt = 1'b0; i_pc_jump = 32'h0000_1230;
        @(negedge i_clock);
        n_checks++;
        if (o_stall !== 1'b1 || o_pc_load !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_release: stall/load got %b/%b want 1/0", o_stall, o_pc_load);
        end
        tick();
        set_idle();
        @(negedge i_clock);
        n_checks++;
        if ({o_pc_load, o_link_we, o_wait_error} !== 3'b100 || o_pc_target !== 32'h0000_1230) begin
            n_fail++;
            $display("FAIL halt_redirect: load/we/err got %b target %h want 100 00001230",
                     {o_pc_load, o_link_we, o_wait_error}, o_pc_target);
        end
        tick();
        if (exp_count < CNT_MAX) exp_count++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                int sel;
                sel = $urandom_range(0, 2);
                i_id_valid = (sel != 0); i_is_jump = (sel != 1); i_halt = (sel == 2);
                i_jump = 2'($urandom); i_rs_busy = 1'($urandom); i_pc_jump = $urandom;
                @(negedge i_clock);
                n_checks++;
                if (o_stall !== 1'b0 || o_pc_load !== 1'b0 ||
                    o_redirect_count !== exp_count[NBC-1:0]) begin
                    n_fail++;
                    $display("FAIL rand_idle it=%0d: stall/load got %b/%b count %0d want 0/0 %0d",
                             it, o_stall, o_pc_load, o_redirect_count, exp_count);
                end
                tick();
            end
            do_jump(2'($urandom), $urandom_range(0, 6), $urandom, $urandom);
        end
    endtask

    task automatic test_back_to_back_saturation();
        for (int j = 0; j < CNT_MAX + 5; j++) begin
            do_jump(JUMP_J, 0, $urandom, $urandom);
        end
        n_checks++;
        if (o_redirect_count !== CNT_MAX[NBC-1:0]) begin
            n_fail++;
            $display("FAIL count_saturate: got %0d want %0d", o_redirect_count, CNT_MAX);
        end
    endtask

    // JALR with rs stuck busy: 15 waiting cycles then error, no redirect.
    task automatic test_wait_error();
        for (int c = 0; c < 16; c++) begin
            i_id_valid = 1'b1; i_is_jump = 1'b1; i_jump = JUMP_JALR; i_halt = 1'b0;
            i_rs_busy = 1'b1; i_pc_jump = $urandom; i_pc_next = $urandom;
            @(negedge i_clock);
            n_checks++;
            if ({o_stall, o_pc_load, o_wait_error} !== 3'b100) begin
                n_fail++;
                $display("FAIL wait_pending cyc=%0d: stall/load/err got %b want 100",
                         c, {o_stall, o_pc_load, o_wait_error});
            end
            tick();
        end
        set_idle();
        exp_err = 1'b1;
        @(negedge i_clock);
        n_checks++;
        if ({o_stall, o_pc_load, o_wait_error} !== 3'b001) begin
            n_fail++;
            $display("FAIL wait_error: stall/load/err got %b want 001",
                     {o_stall, o_pc_load, o_wait_error});
        end
        tick();
        do_jump(JUMP_JAL, 0, 32'h0000_7770, 32'h0000_0600);
    endtask

    task automatic test_reset_in_redirect();
        i_id_valid = 1'b1; i_is_jump = 1'b1; i_jump = JUMP_JAL;
        i_pc_jump = 32'h0000_9990; i_pc_next = 32'h0000_0700;
        tick();
        set_idle();
        n_checks++;
        if (o_pc_load !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_redirect: load got %b want 1", o_pc_load);
        end
        #2;
        i_reset_n = 1'b0;
        #1;
        n_checks++;
        if ({o_stall, o_pc_load, o_flush_if, o_link_we, o_wait_error} !== 5'b0 ||
            o_pc_target !== '0 || o_link_data !== '0 || o_redirect_count !== '0) begin
            n_fail++;
            $display("FAIL reset_redirect: ctrl=%b target=%h link=%h count=%0d want all zero",
                     {o_stall, o_pc_load, o_flush_if, o_link_we, o_wait_error},
                     o_pc_target, o_link_data, o_redirect_count);
        end
        exp_count = 0;
        exp_err = 1'b0;
        @(negedge i_clock);
        i_reset_n = 1'b1;
        tick();
        do_jump(JUMP_J, 0, 32'h0040_0040, 32'h0000_0800);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_halt_detect();
        test_halt_in_wait();
        test_random();
        test_back_to_back_saturation();
        test_wait_error();
        test_reset_in_redirect();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
